// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH general-purpose register file for the arRISCado core.
// One synchronous byte-strobed write port and two independent combinational read ports.
// Entry 0 can be hardwired to zero (RISC-V x0), and an optional bypass forwards the
// write being committed this cycle to the read ports.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears every entry, forces reads to 0
//   we             write enable
//   waddr          write address
//   wdata          write data
//   wstrb          byte write strobes, bit k covers wdata[8k+7:8k]
//   raddr1/rdata1  read port 1 (combinational)
//   raddr2/rdata2  read port 2 (combinational)
module register_file #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  DEPTH    = 32,
  parameter bit           ZERO_REG = 1'b1,
  parameter bit           BYPASS   = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic [ADDR_W-1:0]    raddr1,
  output logic [WIDTH-1:0]     rdata1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [WIDTH-1:0]     rdata2
);

  localparam int unsigned     NumBytes = WIDTH / 8;
  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  // Replace the bytes of old_val selected by strb with the matching bytes of new_val.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]    old_val,
                                                   input logic [WIDTH-1:0]    new_val,
                                                   input logic [NumBytes-1:0] strb);
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int unsigned k = 0; k < NumBytes; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  // An address names a real, writable entry: in range and not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthW) && !(ZERO_REG && (a == '0));
  endfunction

  // A write that will actually land at the next edge; also the bypass qualifier.
  assign wr_ok = rst_n && we && addr_live(waddr);

  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      if (wr_ok && (waddr == ADDR_W'(e))) begin
        mem_d[e] = merge_bytes(mem_q[e], wdata, wstrb);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  // Stored-word selection; out-of-range addresses match no entry and stay 0.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (raddr1 == ADDR_W'(e)) begin
        stored1 = mem_q[e];
      end
      if (raddr2 == ADDR_W'(e)) begin
        stored2 = mem_q[e];
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst_n && addr_live(raddr1)) begin
      rdata1 = stored1;
      if (BYPASS && wr_ok && (waddr == raddr1)) begin
        rdata1 = merge_bytes(stored1, wdata, wstrb);
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst_n && addr_live(raddr2)) begin
      rdata2 = stored2;
      if (BYPASS && wr_ok && (waddr == raddr2)) begin
        rdata2 = merge_bytes(stored2, wdata, wstrb);
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// Four instances: a (32x32, x0 zero, bypass), b (32x32, no zero reg, no bypass),
// c (32x24, x0 zero, bypass), d (64x16, x0 zero, bypass). a/b/c share one stimulus bus.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        we_w;
  logic [3:0]  waddr_w;
  logic [63:0] wdata_w;
  logic [7:0]  wstrb_w;
  logic [3:0]  raddr1_w;
  logic [3:0]  raddr2_w;

  logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b, rdata1_c, rdata2_c;
  logic [63:0] rdata1_d, rdata2_d;
  logic [63:0] rd1 [4];
  logic [63:0] rd2 [4];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model: plain arrays of words, one per instance.
  logic [63:0] mdl       [4][64];
  int unsigned cfg_depth [4] = '{32, 32, 24, 16};
  bit          cfg_zr    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          cfg_byp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned cfg_nb    [4] = '{4, 4, 4, 8};

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] b1;
    logic [31:0] c1;
    logic [31:0] c2;
  } vec_t;

  vec_t vecs [9];

  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .rdata1(rdata1_a), .raddr2(raddr2), .rdata2(rdata2_a)
  );
  register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b)
  );
  register_file #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .rdata1(rdata1_c), .raddr2(raddr2), .rdata2(rdata2_c)
  );
  register_file #(.WIDTH(64), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .we(we_w), .waddr(waddr_w), .wdata(wdata_w), .wstrb(wstrb_w),
    .raddr1(raddr1_w), .rdata1(rdata1_d), .raddr2(raddr2_w), .rdata2(rdata2_d)
  );

  assign rd1[0] = {32'h0, rdata1_a};
  assign rd2[0] = {32'h0, rdata2_a};
  assign rd1[1] = {32'h0, rdata1_b};
  assign rd2[1] = {32'h0, rdata2_b};
  assign rd1[2] = {32'h0, rdata1_c};
  assign rd2[2] = {32'h0, rdata2_c};
  assign rd1[3] = rdata1_d;
  assign rd2[3] = rdata2_d;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] apply_strb(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] strb, input int unsigned nb);
    logic [63:0] mask = '0;
    for (int k = 0; k < int'(nb); k++) begin
      if (strb[k]) mask[8*k +: 8] = 8'hFF;
    end
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic bit live(input int d, input int unsigned a);
    return (a < cfg_depth[d]) && !(cfg_zr[d] && a == 0);
  endfunction

  function automatic void get_in(input int d, output bit w, output int unsigned wa,
                                 output logic [63:0] wd, output logic [7:0] ws,
                                 output int unsigned r1, output int unsigned r2);
    if (d == 3) begin
      w = we_w; wa = waddr_w; wd = wdata_w; ws = wstrb_w; r1 = raddr1_w; r2 = raddr2_w;
    end else begin
      w = we; wa = waddr; wd = {32'h0, wdata}; ws = {4'h0, wstrb}; r1 = raddr1; r2 = raddr2;
    end
  endfunction

  function automatic logic [63:0] exp_read(input int d, input int unsigned ra);
    bit          w;
    int unsigned wa, r1, r2;
    logic [63:0] wd, v;
    logic [7:0]  ws;
    get_in(d, w, wa, wd, ws, r1, r2);
    if (rst_n !== 1'b1 || !live(d, ra)) return 64'h0;
    v = mdl[d][ra];
    if (cfg_byp[d] && w && wa == ra) v = apply_strb(v, wd, ws, cfg_nb[d]);
    return v;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int e = 0; e < 64; e++) mdl[d][e] = '0;
  endtask

  // Apply the pending write to the model, then advance past the edge.
  task automatic tick();
    bit          w;
    int unsigned wa, r1, r2;
    logic [63:0] wd;
    logic [7:0]  ws;
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 4; d++) begin
        get_in(d, w, wa, wd, ws, r1, r2);
        if (w && live(d, wa)) mdl[d][wa] = apply_strb(mdl[d][wa], wd, ws, cfg_nb[d]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    clear_model();
  endtask

  task automatic check_all(input string tag);
    bit          w;
    int unsigned wa, r1, r2;
    logic [63:0] wd;
    logic [7:0]  ws;
    for (int d = 0; d < 4; d++) begin
      get_in(d, w, wa, wd, ws, r1, r2);
      check($sformatf("%s d%0d p1 a%0d", tag, d, r1), rd1[d], exp_read(d, r1));
      check($sformatf("%s d%0d p2 a%0d", tag, d, r2), rd2[d], exp_read(d, r2));
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 4'hF, 5'd7,  5'd0,
                32'h12345678, 32'h0, 32'h12345678, 32'h12345678, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd0,
                32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd3,  32'hAABBCCDD, 4'hF, 5'd3,  5'd7,
                32'hAABBCCDD, 32'h12345678, 32'hAABBCCDD, 32'hAABBCCDD, 32'h12345678};
    vecs[3] = '{1'b1, 5'd3,  32'h11223344, 4'h5, 5'd3,  5'd3,
                32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vecs[4] = '{1'b1, 5'd30, 32'hCAFEBABE, 4'hF, 5'd30, 5'd3,
                32'hCAFEBABE, 32'hAA22CC44, 32'hCAFEBABE, 32'h0, 32'hAA22CC44};
    vecs[5] = '{1'b1, 5'd23, 32'hCAFEF00D, 4'hF, 5'd23, 5'd30,
                32'hCAFEF00D, 32'hCAFEBABE, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
    vecs[6] = '{1'b1, 5'd7,  32'h0,        4'h0, 5'd7,  5'd23,
                32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'h12345678, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 5'd7,  32'h0,        4'hF, 5'd7,  5'd0,
                32'h12345678, 32'h0, 32'h12345678, 32'h12345678, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd6,  5'd14,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    rst_n = 1'b0;
    {we, waddr, wdata, wstrb, raddr1, raddr2} = '0;
    {we_w, waddr_w, wdata_w, wstrb_w, raddr1_w, raddr2_w} = '0;
    clear_model();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("post-reset");

    // Table-driven directed writes, read back after the edge with we dropped.
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; wstrb = vecs[i].wstrb;
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      tick();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d a1", i), rd1[0], {32'h0, vecs[i].a1});
      check($sformatf("vec%0d a2", i), rd2[0], {32'h0, vecs[i].a2});
      check($sformatf("vec%0d b1", i), rd1[1], {32'h0, vecs[i].b1});
      check($sformatf("vec%0d c1", i), rd1[2], {32'h0, vecs[i].c1});
      check($sformatf("vec%0d c2", i), rd2[2], {32'h0, vecs[i].c2});
    end

    // Bypass: a/b differ before the edge, agree after it.
    we = 1'b1; waddr = 5'd9; wdata = 32'h1; wstrb = 4'hF;
    tick();
    wdata = 32'h55; raddr1 = 5'd9; raddr2 = 5'd9;
    #2;
    check("byp pre a1", rd1[0], 64'h55);
    check("byp pre a2", rd2[0], 64'h55);
    check("byp pre b1", rd1[1], 64'h1);
    check("byp pre b2", rd2[1], 64'h1);
    tick();
    we = 1'b0;
    #1;
    check("byp post b1", rd1[1], 64'h55);
    check("byp post b2", rd2[1], 64'h55);

    // Back-to-back strobed writes to one entry.
    we = 1'b1; waddr = 5'd12;
    wdata = 32'hAAAAAAAA; wstrb = 4'hF; tick();
    wdata = 32'h000000BB; wstrb = 4'h1; tick();
    wdata = 32'h0000CC00; wstrb = 4'h2; tick();
    we = 1'b0; raddr1 = 5'd12;
    #1;
    check("b2b a1", rd1[0], 64'hAAAACCBB);
    check("b2b b1", rd1[1], 64'hAAAACCBB);

    // Wide instance: upper then lower half via strobes.
    we_w = 1'b1; waddr_w = 4'd1; wdata_w = 64'h0123456789ABCDEF; wstrb_w = 8'hF0;
    raddr1_w = 4'd1;
    #2;
    check("wide pre d1", rd1[3], 64'h0123456700000000);
    tick();
    wdata_w = 64'hFEDCBA9876543210; wstrb_w = 8'h0F;
    tick();
    we_w = 1'b0;
    #1;
    check("wide post d1", rd1[3], 64'h0123456776543210);

    // Reset mid-cycle clears the array with no clock edge involved.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    we = 1'b0; raddr1 = 5'd5;
    #1;
    check("rstclr before a1", rd1[0], 64'hDEADBEEF);
    assert_reset();
    #1;
    check("rstclr during a1", rd1[0], 64'h0);
    #9;
    rst_n = 1'b1;
    #1;
    check("rstclr after a1", rd1[0], 64'h0);
    check("rstclr after b1", rd1[1], 64'h0);
    check("rstclr wide d1", rd1[3], 64'h0);

    // Reset with a write pending: write lost, bypass off; first edge after release writes.
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h77; wstrb = 4'hF; raddr1 = 5'd9; raddr2 = 5'd9;
    #2;
    check("rstwr pre a1", rd1[0], 64'h77);
    assert_reset();
    #1;
    check("rstwr low a1", rd1[0], 64'h0);
    check("rstwr low b1", rd1[1], 64'h0);
    @(posedge clk);
    #1;
    check("rstwr edge b1", rd1[1], 64'h0);
    rst_n = 1'b1;
    #2;
    check("rstwr rel a1", rd1[0], 64'h77);
    check("rstwr rel b1", rd1[1], 64'h0);
    tick();
    check("rstwr first b1", rd1[1], 64'h77);
    we = 1'b0;

    // Randomised traffic against the model, with occasional async reset pulses.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      we = ($urandom_range(0, 3) != 0);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      we_w = ($urandom_range(0, 3) != 0);
      waddr_w = 4'($urandom_range(0, 15));
      wdata_w = {$urandom, $urandom};
      wstrb_w = 8'($urandom_range(0, 255));
      raddr1_w = ($urandom_range(0, 3) == 0) ? waddr_w : 4'($urandom_range(0, 15));
      raddr2_w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #1;
        assert_reset();
        #1;
        check_all("rnd-rst");
        #1;
        rst_n = 1'b1;
        #5;
      end else begin
        #8;
      end
      check_all($sformatf("rnd%0d pre", cyc));
      tick();
      check_all($sformatf("rnd%0d post", cyc));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
